// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_pkg
// Description : Shared state encoding and access-size codes for the memory
//               port arbiter and its load-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRD   = 2'd2,
        DWR   = 2'd3
    } arb_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational sign/zero extension of right-justified raw
//               memory read data according to the access size.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [63:0] data_o
);

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            SZ_B:    data_o = unsigned_i ? {56'd0, rdata_i[7:0]}
                                         : {{56{rdata_i[7]}}, rdata_i[7:0]};
            SZ_H:    data_o = unsigned_i ? {48'd0, rdata_i[15:0]}
                                         : {{48{rdata_i[15]}}, rdata_i[15:0]};
            SZ_W:    data_o = unsigned_i ? {32'd0, rdata_i[31:0]}
                                         : {{32{rdata_i[31]}}, rdata_i[31:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               load/store, holding each response as a level until released.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 56,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              phi1,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instruction_address,
    input  logic              input_instruction_request,
    output logic [31:0]       input_instruction,
    output logic              input_instruction_valid,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [1:0]        data_size,
    input  logic              input_data_unsigned,
    input  logic              input_data_request,
    output logic [63:0]       input_data,
    output logic              input_data_valid,
    input  logic [63:0]       output_data,
    input  logic              output_data_request,
    output logic              output_data_complete,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_read,
    output logic              mem_write,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_error
);

    localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam int              WC_W       = $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       instr_q, instr_d;
    logic              ivalid_q, ivalid_d;
    logic [ADDR_W-1:0] itag_q, itag_d;
    logic [63:0]       ldata_q, ldata_d;
    logic              dvalid_q, dvalid_d;
    logic              dcomplete_q, dcomplete_d;
    logic              bus_error_q, bus_error_d;
    logic              uns_q, uns_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [ADDR_W-1:0] iaddr_prev_q;

    logic        strobe, op_done, op_timeout;
    logic        fetch_inval, data_inval, data_slot;
    logic        fetch_pend, data_pend;
    logic        grant_fetch, grant_rd, grant_wr;
    logic        fetch_fill, rd_fill, wr_fill;
    logic [63:0] ext_data;

    load_extend u_load_extend (
        .rdata_i    (mem_rdata),
        .size_i     (mem_size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    assign strobe     = mem_read_q | mem_write_q;
    assign op_done    = strobe & mem_ready;
    assign op_timeout = strobe & ~mem_ready & (wait_q == WAIT_LAST);

    assign data_slot   = dvalid_q | dcomplete_q;
    assign fetch_inval = ~input_instruction_request | (instruction_address != itag_q);
    assign data_inval  = (instruction_address != iaddr_prev_q)
                       | ~(input_data_request | output_data_request);

    // A data slot being released this cycle already counts as pending, so
    // back-to-back data ops see no idle gap the fetch could slip into.
    assign fetch_pend = input_instruction_request & ~(ivalid_q & (itag_q == instruction_address));
    assign data_pend  = (input_data_request | output_data_request) & (~data_slot | data_inval);

    // Results of ops whose request dropped or whose address moved are discarded.
    assign fetch_fill = (state_q == FETCH) & op_done & input_instruction_request
                      & (instruction_address == mem_addr_q);
    assign rd_fill    = (state_q == DRD) & op_done & input_data_request
                      & (instruction_address == iaddr_prev_q);
    assign wr_fill    = (state_q == DWR) & op_done & output_data_request
                      & (instruction_address == iaddr_prev_q);

    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if ((starve_q == STARVE_MAX) && fetch_pend) begin
                    grant_fetch = 1'b1;
                    state_d     = FETCH;
                end else if (data_pend) begin
                    if (input_data_request) begin
                        grant_rd = 1'b1;
                        state_d  = DRD;
                    end else begin
                        grant_wr = 1'b1;
                        state_d  = DWR;
                    end
                end else if (fetch_pend) begin
                    grant_fetch = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH, DRD, DWR: begin
                if (op_done || op_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_size_d  = mem_size_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        ivalid_d    = ivalid_q;
        itag_d      = itag_q;
        ldata_d     = ldata_q;
        dvalid_d    = dvalid_q;
        dcomplete_d = dcomplete_q;
        bus_error_d = 1'b0;
        uns_d       = uns_q;
        starve_d    = starve_q;
        wait_d      = '0;

        if (ivalid_q && fetch_inval) begin
            ivalid_d = 1'b0;
        end
        if (data_slot && data_inval) begin
            dvalid_d    = 1'b0;
            dcomplete_d = 1'b0;
        end

        if (grant_fetch) begin
            mem_read_d = 1'b1;
            mem_addr_d = instruction_address;
            mem_size_d = SZ_W;
            starve_d   = '0;
        end
        if (grant_rd || grant_wr) begin
            mem_read_d  = grant_rd;
            mem_write_d = grant_wr;
            mem_addr_d  = data_address;
            mem_size_d  = data_size;
            uns_d       = input_data_unsigned;
            bus_error_d = grant_rd & output_data_request;
            if (grant_wr) begin
                mem_wdata_d = output_data;
            end
            if (fetch_pend && (starve_q < STARVE_MAX)) begin
                starve_d = starve_q + SC_W'(1);
            end
        end

        if (strobe) begin
            if (op_done || op_timeout) begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                bus_error_d = op_timeout;
            end else begin
                wait_d = wait_q + WC_W'(1);
            end
        end

        if (fetch_fill) begin
            instr_d  = mem_rdata[31:0];
            ivalid_d = 1'b1;
            itag_d   = instruction_address;
        end
        if (rd_fill) begin
            ldata_d  = ext_data;
            dvalid_d = 1'b1;
        end
        if (wr_fill) begin
            dcomplete_d = 1'b1;
        end
    end

    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            mem_addr_q   <= '0;
            mem_size_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            instr_q      <= '0;
            ivalid_q     <= 1'b0;
            itag_q       <= '0;
            ldata_q      <= '0;
            dvalid_q     <= 1'b0;
            dcomplete_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            uns_q        <= 1'b0;
            starve_q     <= '0;
            wait_q       <= '0;
            iaddr_prev_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_size_q   <= mem_size_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_q      <= instr_d;
            ivalid_q     <= ivalid_d;
            itag_q       <= itag_d;
            ldata_q      <= ldata_d;
            dvalid_q     <= dvalid_d;
            dcomplete_q  <= dcomplete_d;
            bus_error_q  <= bus_error_d;
            uns_q        <= uns_d;
            starve_q     <= starve_d;
            wait_q       <= wait_d;
            iaddr_prev_q <= instruction_address;
        end
    end

    assign mem_addr                = mem_addr_q;
    assign mem_size                = mem_size_q;
    assign mem_read                = mem_read_q;
    assign mem_write               = mem_write_q;
    assign mem_wdata               = mem_wdata_q;
    assign input_instruction       = instr_q;
    assign input_instruction_valid = ivalid_q;
    assign input_data              = ldata_q;
    assign input_data_valid        = dvalid_q;
    assign output_data_complete    = dcomplete_q;
    assign bus_error               = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 56;

    typedef struct packed {
        logic [1:0]  size;
        logic        uns;
        logic [63:0] rdata;
        logic [63:0] exp;
    } ld_vec_t;

    logic          phi1 = 1'b0;
    logic          rst;
    logic [AW-1:0] instruction_address;
    logic          input_instruction_request;
    logic [31:0]   input_instruction;
    logic          input_instruction_valid;
    logic [AW-1:0] data_address;
    logic [1:0]    data_size;
    logic          input_data_unsigned;
    logic          input_data_request;
    logic [63:0]   input_data;
    logic          input_data_valid;
    logic [63:0]   output_data;
    logic          output_data_request;
    logic          output_data_complete;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;
    logic          mem_read;
    logic          mem_write;
    logic [63:0]   mem_wdata;
    logic [63:0]   mem_rdata;
    logic          mem_ready;
    logic          bus_error;

    int      n_assert = 0;
    int      n_fail   = 0;
    ld_vec_t vecs[7];

    always #5 phi1 = ~phi1;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .phi1                      (phi1),
        .rst                       (rst),
        .instruction_address       (instruction_address),
        .input_instruction_request (input_instruction_request),
        .input_instruction         (input_instruction),
        .input_instruction_valid   (input_instruction_valid),
        .data_address              (data_address),
        .data_size                 (data_size),
        .input_data_unsigned       (input_data_unsigned),
        .input_data_request        (input_data_request),
        .input_data                (input_data),
        .input_data_valid          (input_data_valid),
        .output_data               (output_data),
        .output_data_request       (output_data_request),
        .output_data_complete      (output_data_complete),
        .mem_addr                  (mem_addr),
        .mem_size                  (mem_size),
        .mem_read                  (mem_read),
        .mem_write                 (mem_write),
        .mem_wdata                 (mem_wdata),
        .mem_rdata                 (mem_rdata),
        .mem_ready                 (mem_ready),
        .bus_error                 (bus_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            @(negedge phi1);
            n++;
        end while (!(mem_read || mem_write) && n < 20);
        check(tag, 64'(mem_read | mem_write), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int be;

        vecs[0] = '{2'd0, 1'b0, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1] = '{2'd0, 1'b1, 64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080};
        vecs[2] = '{2'd1, 1'b0, 64'h0000_0000_1234_8001, 64'hFFFF_FFFF_FFFF_8001};
        vecs[3] = '{2'd1, 1'b0, 64'hAAAA_AAAA_AAAA_7FFF, 64'h0000_0000_0000_7FFF};
        vecs[4] = '{2'd2, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{2'd2, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000};
        vecs[6] = '{2'd3, 1'b0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};

        rst = 1'b0;
        instruction_address = '0;
        input_instruction_request = 1'b0;
        data_address = '0;
        data_size = 2'd0;
        input_data_unsigned = 1'b0;
        input_data_request = 1'b0;
        output_data = '0;
        output_data_request = 1'b0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // reset state
        @(negedge phi1);
        @(negedge phi1);
        check("rst_mem_read",  64'(mem_read), 64'd0);
        check("rst_mem_write", 64'(mem_write), 64'd0);
        check("rst_mem_addr",  64'(mem_addr), 64'd0);
        check("rst_ivalid",    64'(input_instruction_valid), 64'd0);
        check("rst_dvalid",    64'(input_data_valid), 64'd0);
        check("rst_dcomplete", 64'(output_data_complete), 64'd0);
        check("rst_bus_error", 64'(bus_error), 64'd0);

        // fetch only
        rst = 1'b1;
        instruction_address = 56'h100;
        input_instruction_request = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 64'h0050_0093;
        @(negedge phi1);
        check("fetch_strobe", 64'(mem_read), 64'd1);
        check("fetch_addr",   64'(mem_addr), 64'h100);
        check("fetch_size",   64'(mem_size), 64'd2);
        check("fetch_early",  64'(input_instruction_valid), 64'd0);
        @(negedge phi1);
        check("fetch_valid",  64'(input_instruction_valid), 64'd1);
        check("fetch_word",   64'(input_instruction), 64'h0050_0093);
        check("fetch_strobe_drop", 64'(mem_read), 64'd0);
        repeat (3) @(negedge phi1);
        check("fetch_hold",    64'(input_instruction_valid), 64'd1);
        check("fetch_no_refetch", 64'(mem_read), 64'd0);
        instruction_address = 56'h104;
        mem_rdata = 64'h00A0_0113;
        @(negedge phi1);
        check("fetch_inval",   64'(input_instruction_valid), 64'd0);
        check("refetch_strobe", 64'(mem_read), 64'd1);
        check("refetch_addr",  64'(mem_addr), 64'h104);
        @(negedge phi1);
        check("refetch_valid", 64'(input_instruction_valid), 64'd1);
        check("refetch_word",  64'(input_instruction), 64'h00A0_0113);

        // loads with size/sign extension
        data_address = 56'h2003;
        foreach (vecs[i]) begin
            data_size = vecs[i].size;
            input_data_unsigned = vecs[i].uns;
            mem_rdata = vecs[i].rdata;
            input_data_request = 1'b1;
            @(negedge phi1);
            check($sformatf("ld_strobe[%0d]", i), 64'(mem_read), 64'd1);
            check($sformatf("ld_addr[%0d]", i),   64'(mem_addr), 64'h2003);
            @(negedge phi1);
            check($sformatf("ld_valid[%0d]", i),  64'(input_data_valid), 64'd1);
            check($sformatf("ld_data[%0d]", i),   input_data, vecs[i].exp);
            input_data_request = 1'b0;
            @(negedge phi1);
            check($sformatf("ld_drop[%0d]", i),   64'(input_data_valid), 64'd0);
        end
        check("fetch_held_across_loads", 64'(input_instruction_valid), 64'd1);
        check("fetch_word_held",         64'(input_instruction), 64'h00A0_0113);

        // store with three wait cycles
        data_address = 56'h3000;
        data_size = 2'd3;
        output_data = 64'hDEAD_BEEF_CAFE_F00D;
        mem_ready = 1'b0;
        output_data_request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge phi1);
            check($sformatf("st_strobe[%0d]", i), 64'(mem_write), 64'd1);
            check($sformatf("st_wdata[%0d]", i),  mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            check($sformatf("st_addr[%0d]", i),   64'(mem_addr), 64'h3000);
            if (i == 3) mem_ready = 1'b1;
        end
        @(negedge phi1);
        check("st_strobe_drop", 64'(mem_write), 64'd0);
        check("st_complete",    64'(output_data_complete), 64'd1);
        repeat (2) @(negedge phi1);
        check("st_complete_hold", 64'(output_data_complete), 64'd1);
        output_data_request = 1'b0;
        @(negedge phi1);
        check("st_complete_drop", 64'(output_data_complete), 64'd0);

        // illegal load+store: load wins, bus_error pulses
        mem_rdata = 64'h0123_4567_89AB_CDEF;
        input_data_request = 1'b1;
        output_data_request = 1'b1;
        @(negedge phi1);
        check("both_read",     64'(mem_read), 64'd1);
        check("both_no_write", 64'(mem_write), 64'd0);
        check("both_bus_error", 64'(bus_error), 64'd1);
        @(negedge phi1);
        check("both_ld_valid", 64'(input_data_valid), 64'd1);
        check("both_ld_data",  input_data, 64'h0123_4567_89AB_CDEF);
        check("both_err_pulse", 64'(bus_error), 64'd0);
        input_data_request = 1'b0;
        output_data_request = 1'b0;
        @(negedge phi1);

        // starvation: four data grants, then the fetch is forced
        instruction_address = 56'h400;
        data_address = 56'h3000;
        data_size = 2'd2;
        input_data_unsigned = 1'b1;
        mem_rdata = '0;
        input_data_request = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_strobe($sformatf("starve_wait[%0d]", g));
            if (g < 4) begin
                check($sformatf("starve_data_grant[%0d]", g), 64'(mem_addr), 64'h3000);
                @(negedge phi1);
                check($sformatf("starve_data_done[%0d]", g), 64'(input_data_valid), 64'd1);
                instruction_address = instruction_address + 56'd4;
            end else begin
                check("starve_fetch_grant", 64'(mem_addr), 64'h410);
                check("starve_fetch_size",  64'(mem_size), 64'd2);
            end
        end
        @(negedge phi1);
        check("starve_fetch_done", 64'(input_instruction_valid), 64'd1);
        input_data_request = 1'b0;
        repeat (2) @(negedge phi1);

        // timeout on a load, then retry
        input_instruction_request = 1'b0;
        repeat (2) @(negedge phi1);
        mem_ready = 1'b0;
        data_address = 56'h5000;
        data_size = 2'd3;
        input_data_request = 1'b1;
        wait_strobe("to_wait");
        hi = 0;
        be = 0;
        while (mem_read && hi < 300) begin
            hi++;
            @(negedge phi1);
            if (bus_error) be++;
        end
        check("to_strobe_cycles", 64'(hi), 64'd255);
        check("to_bus_error_pulses", 64'(be), 64'd1);
        @(negedge phi1);
        check("to_retry_strobe", 64'(mem_read), 64'd1);
        check("to_retry_addr",   64'(mem_addr), 64'h5000);
        check("to_err_cleared",  64'(bus_error), 64'd0);
        check("to_slot_invalid", 64'(input_data_valid), 64'd0);

        // asynchronous reset during a store
        input_data_request = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_async_read", 64'(mem_read), 64'd0);
        #2;
        rst = 1'b1;
        data_address = 56'h6000;
        output_data = 64'h1122_3344_5566_7788;
        output_data_request = 1'b1;
        @(negedge phi1);
        check("rst_st_strobe", 64'(mem_write), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_write", 64'(mem_write), 64'd0);
        check("rst_mid_addr",  64'(mem_addr), 64'd0);
        check("rst_mid_wdata", mem_wdata, 64'd0);
        check("rst_mid_complete", 64'(output_data_complete), 64'd0);
        output_data_request = 1'b0;
        mem_ready = 1'b1;
        @(negedge phi1);
        rst = 1'b1;
        repeat (2) @(negedge phi1);
        check("rst_idle_write",    64'(mem_write), 64'd0);
        check("rst_idle_read",     64'(mem_read), 64'd0);
        check("rst_idle_complete", 64'(output_data_complete), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch port and its data load/store port.
- Sits between the core and the memory/bus model.
- Serialises fetch and data transactions and sign/zero-extends load data.
- Holds each response valid/complete as a level until the core moves on, as the core's retire logic requires.

Parameters:
- ADDR_W, 56, physical address width (core and memory side).
- STARVE_LIMIT, 4, max consecutive data grants while a fetch waits before the fetch is forced.
- TIMEOUT, 255, cycles a memory op may wait for mem_ready before it is aborted with bus_error.

Ports:
- phi1  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- instruction_address  in  ADDR_W  fetch address.
- input_instruction_request  in  1  fetch request (level).
- input_instruction  out  32  fetched word.
- input_instruction_valid  out  1  input_instruction valid for the current instruction_address.
- data_address  in  ADDR_W  load/store address.
- data_size  in  2  0=byte, 1=half, 2=word, 3=double.
- input_data_unsigned  in  1  zero-extend load when 1.
- input_data_request  in  1  load request (level).
- input_data  out  64  extended load data.
- input_data_valid  out  1  load data valid.
- output_data  in  64  store data, right-justified.
- output_data_request  in  1  store request (level).
- output_data_complete  out  1  store done.
- mem_addr  out  ADDR_W  memory address.
- mem_size  out  2  memory access size.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, right-justified raw.
- mem_ready  in  1  memory completes the current op this cycle.
- bus_error  out  1  one-cycle pulse on a TIMEOUT abort.

Behaviour:
- Reset: the following are 0, state IDLE, counters 0, fetch/data response slots invalid:
  - all outputs,
  - latched fetch/data tags.
- All outputs are registered.
- States:
  - IDLE.
  - FETCH: mem_read=1, mem_size=2, mem_addr=instruction_address.
  - DRD: mem_read=1, data_size/data_address.
  - DWR: mem_write=1, mem_wdata=output_data.
- mem_addr, mem_size and mem_wdata are held stable for the entire time the strobe is high.
- Pending conditions, evaluated in IDLE:
  - fetch pending = input_instruction_request && !(fetch slot valid && tag == instruction_address).
  - data pending = (input_data_request || output_data_request) && data slot not valid.
  - input_data_request and output_data_request both high is illegal. The load wins and bus_error pulses.
- Grant:
  - Data has priority over fetch.
  - If starve_cnt == STARVE_LIMIT and a fetch is pending, the fetch is granted.
  - starve_cnt increments on each data grant while a fetch is pending, saturates, and clears on any fetch grant.
- Completion:
  - A cycle with strobe && mem_ready completes the op. The state returns to IDLE next edge, and the strobe drops that same edge.
  - Minimum latency: request seen at edge N, strobe high after N+1, valid/complete high after N+2 when mem_ready is already 1.
- FETCH completion: input_instruction = mem_rdata[31:0]; fetch slot valid; tag = instruction_address.
- DRD completion:
  - input_data = mem_rdata extended by data_size: sign-extend bit 7/15/31 unless input_data_unsigned, in which case zero-extend.
  - Size 3 passes through unchanged.
  - Data slot valid.
- DWR completion: output_data_complete=1; data slot valid.
- Slot hold and invalidation:
  - Valid/complete stay high while the slot is valid.
  - Fetch slot invalidates when instruction_address != tag or the request drops.
  - Data slot invalidates on any instruction_address change or when both data requests drop.
  - Invalidation takes effect at the next edge, and outputs drop then.
  - A slot is never re-filled in the same cycle it invalidates.
- Timeout:
  - wait_cnt counts strobe cycles without mem_ready.
  - When wait_cnt reaches TIMEOUT: drop the strobe, return to IDLE, pulse bus_error, leave the slot invalid, clear wait_cnt. The request is retried from IDLE.
- A request that drops mid-op does not abort the op. It completes and the result is discarded (slot not set).
- An asynchronous rst assertion mid-op drops the strobe immediately; no completion is reported.

Decomposition:
- Shared package mem_pkg:
  - typedef arb_state_t {IDLE, FETCH, DRD, DWR},
  - size constants SZ_B/SZ_H/SZ_W/SZ_D.
- Sub-module load_extend: combinational size/sign extension of mem_rdata. It is reusable by the mmu.

Test Plan:
- Fetch only: instruction_address=0x100, mem_ready tied 1, mem_rdata=0x00500093 -> mem_read at cycle 1 with mem_addr=0x100, mem_size=2; input_instruction_valid from cycle 2, held while the address is stable; dropped one edge after the address changes to 0x104.
- Fetch then load byte: after the fetch, input_data_request with data_address=0x2003, size 0, signed, mem_rdata=0x80 -> input_data=0xFFFFFFFFFFFFFF80. Repeat unsigned -> 0x80.
- Store: output_data_request, size 3, output_data=0xDEADBEEFCAFEF00D, mem_ready after 3 wait cycles -> mem_write held 4 cycles with stable wdata; output_data_complete high until the request drops.
- Starvation: data slot cycled 5 times while a new fetch address is pending, STARVE_LIMIT=4 -> the 5th grant is FETCH.
- Timeout: mem_ready held 0 on a load, TIMEOUT=255 -> strobe drops after 255 cycles, bus_error pulses once, a retry strobe follows.
- Reset mid-DWR: rst driven low during mem_write -> mem_write and all outputs 0 immediately; state IDLE after rst returns high.
